arbitro_ula_rr: RTL and testbench
=================================

# arbitro_ula_rr

Round-robin arbiter and sequencer that shares one ALU datapath among four requesters. Grants one requester at a time and drives the 2-bit select of the 4-to-1 operand/result multiplexers (`mux_4_para_1` instances). Issues a one-cycle start to the ALU sequencer and waits for its done. Returns a per-requester acknowledge, or aborts with a timeout pulse if done never arrives.

## Interface
- `MAX_WAIT`, default 15: maximum WAIT cycles before abort. Legal range is ≥1.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request level per requester; bit i belongs to requester i.
- `done`  in  1  ALU operation complete; single-cycle pulse from the datapath.
- `sel`  out  2  binary index of the granted requester; drives `S` of every 4:1 mux.
- `grant`  out  4  one-hot grant; all-zero when idle.
- `start`  out  1  one-cycle pulse launching the ALU operation.
- `ack`  out  4  one-hot, one-cycle pulse to the requester whose operation completed.
- `timeout`  out  1  one-cycle pulse when an operation is aborted.
- `busy`  out  1  high from grant until release.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE
  - `grant`=0, `sel`=0, `start`=0, `ack`=0, `timeout`=0, `busy`=0
  - round-robin pointer `last`=3, so requester 0 has first priority
  - wait counter=0
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If `req`≠0, choose the first set bit scanning `last+1`, `last+2`, … modulo 4.
  - Load `grant`/`sel` for that index, set `busy`=1, go to ISSUE.
  - If `req`=0, stay in IDLE.
- ISSUE: `start`=1 for exactly this cycle, clear the counter, go to WAIT.
- WAIT:
  - `done`=1: pulse `ack[sel]`, set `last`=`sel`, clear `grant` and `busy`, go to IDLE.
  - Otherwise the counter increments.
  - If the counter reaches `MAX_WAIT` with no `done`: pulse `timeout`, set `last`=`sel`, clear `grant` and `busy`, go to IDLE. No `ack` is issued.
- `sel` holds its last value after release; only `grant` indicates validity.
- Counter width is `$clog2(MAX_WAIT+1)`. The counter never wraps; it saturates at the compare point.
- Boundary rules:
  - `done` in IDLE or ISSUE is ignored.
  - `done` asserted in the same cycle the limit is reached: `done` wins. Issue `ack`, no `timeout`.
  - Granted requester drops `req` mid-operation: ignored; the operation runs to `ack`/`timeout`.
  - All four requesting continuously: grants rotate 0,1,2,3,0,…
  - A single requester holding `req`: it is re-granted after every release.
  - `rst` mid-operation: immediate return to reset values, no `ack` or `timeout` pulse, pointer back to 3.

## Timing
- `req` sampled in IDLE at edge t. At t+1: `grant`/`sel`/`busy` valid and `start`=1 (ISSUE). At t+2: WAIT.
- `done` sampled high at edge d during WAIT: `ack` at d+1, `grant`=0 at d+1, state IDLE at d+1.
- Next grant is at d+2 at the earliest.
- Minimum turnaround with `done` on the first WAIT cycle is 3 cycles from request to `ack`, then 1 idle cycle.
- With no `done`, `timeout` pulses at t+2+`MAX_WAIT`.
- `start`, `ack` and `timeout` are never high for more than one consecutive cycle.
- `ack` and `timeout` are mutually exclusive.

## Structure
- Shared package `ula_pkg`:
  - `N_REQ`=4
  - `SEL_W`=2
  - state encoding constants `ST_IDLE`=2'd0, `ST_ISSUE`=2'd1, `ST_WAIT`=2'd2
- Sub-module `prioridade_rr_4` (combinational):
  - inputs: `req[3:0]`, `last[1:0]`
  - outputs: `idx[1:0]`, `valid`
- The top block holds the FSM, pointer, counter and output registers.

## Test plan
- Reset, then `req`=4'b0100; `done` pulsed on the 2nd WAIT cycle → `grant`=4'b0100, `sel`=2 and `start` one cycle after request; `ack`=4'b0100 one cycle after `done`.
- `req`=4'b1111 held; `done` each op → grant order 0,1,2,3,0; `ack` sequence 0001,0010,0100,1000,0001.
- `MAX_WAIT`=4, `req`=4'b0010, no `done` → `timeout` pulses 6 cycles after request sampling; `ack` stays 0; next `req`=4'b0011 grants requester 0.
- `MAX_WAIT`=4, `done` coincident with the limit cycle → `ack`=4'b0001, `timeout`=0.
- `rst` asserted during WAIT for requester 2 → next cycle all outputs 0; subsequent `req`=4'b0101 grants requester 0.
- `done` pulsed while IDLE and `req`=0 → no `ack`, state stays IDLE, `busy`=0.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU arbiter slice: requester count, select
// width and the arbiter FSM state type.
package ula_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/arbitro_ula_rr_prioridade.sv
// prioridade_rr_4: combinational round-robin priority picker.
// Ports:
//   req   [3:0] in  request vector
//   last  [1:0] in  index granted most recently
//   idx   [1:0] out first requesting index after last (modulo 4)
//   valid       out at least one request present
module prioridade_rr_4
  import ula_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             valid
);

  logic [SEL_W-1:0] cand;

  // Scan last+1 .. last+4; the 2-bit add wraps naturally, last+4 == last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = last + SEL_W'(i);
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_ula_rr.sv
// arbitro_ula_rr: round-robin arbiter/sequencer sharing one ALU among four
// requesters. Grants one requester, pulses start, waits for done, then
// pulses ack for that requester or timeout after MAX_WAIT wait cycles.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req   [3:0]   request levels
//   done          ALU completion pulse
//   sel   [1:0]   granted index (mux select), holds after release
//   grant [3:0]   one-hot grant, zero when idle
//   start         one-cycle launch pulse
//   ack   [3:0]   one-hot completion pulse
//   timeout       one-cycle abort pulse
//   busy          high from grant until release
module arbitro_ula_rr
  import ula_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             start,
  output logic [N_REQ-1:0] ack,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t           state_q;
  logic [SEL_W-1:0] last_q;
  logic [SEL_W-1:0] sel_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] ack_q;
  logic             start_q;
  logic             timeout_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;

  prioridade_rr_4 u_prio (
    .req   (req),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= '1;
      sel_q     <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      start_q   <= 1'b0;
      ack_q     <= '0;
      timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            sel_q   <= pick_idx;
            grant_q <= N_REQ'(1) << pick_idx;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // done has priority over the limit in the same cycle
          if (done) begin
            ack_q   <= N_REQ'(1) << sel_q;
            last_q  <= sel_q;
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q     <= cnt_d;
            timeout_q <= 1'b1;
            last_q    <= sel_q;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign start   = start_q;
  assign ack     = ack_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_arbitro_ula_rr.sv
// Directed bench for arbitro_ula_rr with MAX_WAIT = 4.
module tb_arbitro_ula_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       start;
  logic [3:0] ack;
  logic       timeout;
  logic       busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  arbitro_ula_rr #(.MAX_WAIT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .start   (start),
    .ack     (ack),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, ".grant"},   8'(grant),   8'h0);
    check({tag, ".start"},   8'(start),   8'h0);
    check({tag, ".ack"},     8'(ack),     8'h0);
    check({tag, ".timeout"}, 8'(timeout), 8'h0);
    check({tag, ".busy"},    8'(busy),    8'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_oh;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_idle_outs("reset");
    check("reset.sel", 8'(sel), 8'h0);

    // single request, done on 2nd WAIT cycle, req dropped mid-operation
    req = 4'b0100;
    step();
    req = 4'b0000;
    check("s1.grant", 8'(grant), 8'h04);
    check("s1.sel",   8'(sel),   8'h02);
    check("s1.start", 8'(start), 8'h1);
    check("s1.busy",  8'(busy),  8'h1);
    step();
    check("s1.start_once", 8'(start), 8'h0);
    check("s1.grant_hold", 8'(grant), 8'h04);
    step();
    check("s1.ack_early", 8'(ack), 8'h0);
    done = 1'b1;
    step();
    done = 1'b0;
    check("s1.ack",     8'(ack),     8'h04);
    check("s1.timeout", 8'(timeout), 8'h0);
    check("s1.grant0",  8'(grant),   8'h0);
    check("s1.busy0",   8'(busy),    8'h0);
    check("s1.sel_hold", 8'(sel),    8'h02);
    step();
    check("s1.ack_once", 8'(ack), 8'h0);

    // rotation with all four requesting, pointer back to 3 by reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      step();
      check($sformatf("rr%0d.grant", k), 8'(grant), 8'(exp_oh));
      check($sformatf("rr%0d.start", k), 8'(start), 8'h1);
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      check($sformatf("rr%0d.ack", k), 8'(ack), 8'(exp_oh));
      if (k == 4) req = 4'b0000;
    end
    step();
    check("rr.idle_grant", 8'(grant), 8'h0);

    // timeout: request sampled at t, timeout at t+6
    req = 4'b0010;
    step();
    req = 4'b0000;
    check("to.grant", 8'(grant), 8'h02);
    for (int c = 2; c <= 5; c++) begin
      step();
      check($sformatf("to.t%0d.timeout", c), 8'(timeout), 8'h0);
      check($sformatf("to.t%0d.ack", c), 8'(ack), 8'h0);
    end
    step();
    check("to.timeout", 8'(timeout), 8'h1);
    check("to.ack",     8'(ack),     8'h0);
    check("to.grant0",  8'(grant),   8'h0);
    check("to.busy0",   8'(busy),    8'h0);
    req = 4'b0011;
    step();
    req = 4'b0000;
    check("to.pulse_once", 8'(timeout), 8'h0);
    check("to.next_grant", 8'(grant),   8'h01);
    check("to.next_sel",   8'(sel),     8'h00);

    // done coincident with the limit edge (t+6)
    for (int c = 2; c <= 5; c++) step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("lim.ack",     8'(ack),     8'h01);
    check("lim.timeout", 8'(timeout), 8'h0);
    step();
    check("lim.after_ack",     8'(ack),     8'h0);
    check("lim.after_timeout", 8'(timeout), 8'h0);

    // reset during WAIT for requester 2 (pointer is 0 here)
    req = 4'b0100;
    step();
    req = 4'b0000;
    check("rst.grant", 8'(grant), 8'h04);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outs("rst");
    check("rst.sel", 8'(sel), 8'h0);
    req = 4'b0101;
    step();
    req = 4'b0000;
    check("rst.next_grant", 8'(grant), 8'h01);
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("rst.ack", 8'(ack), 8'h01);
    step();

    // done while idle is ignored
    done = 1'b1;
    step();
    done = 1'b0;
    check_idle_outs("idle_done");
    step();
    check_idle_outs("idle_done2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
